// File: rtl/nr_float_pkg.sv
// Shared definitions for the normalised float word used by int_to_nr_float
// and nr_div: mantissa/exponent widths, fixed-point location, converter
// state encoding and the sign/magnitude -> packed {m,e} helper.
package nr_float_pkg;

  localparam int MANTISSA_W         = 15;
  localparam int EXP_W              = 8;
  localparam int FIX_POINT_LOCATION = 14;
  localparam int FLOAT_W            = MANTISSA_W + EXP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Turns a sign bit and a 14-bit normalised magnitude into the two's-complement
  // mantissa and concatenates the exponent below it.
  function automatic logic [FLOAT_W-1:0] pack_float(
    input logic                          sign,
    input logic [FIX_POINT_LOCATION-1:0] mag,
    input logic [EXP_W-1:0]              exp_val
  );
    logic [MANTISSA_W-1:0] mant;
    mant = ({MANTISSA_W{sign}} ^ {1'b0, mag}) + {{(MANTISSA_W-1){1'b0}}, sign};
    return {mant, exp_val};
  endfunction

endpackage

// File: rtl/int_to_nr_float.sv
// Signed integer -> normalised float converter (value = m * 2^(e-14)).
// Normalises iteratively, one shift per cycle, between valid/ready handshakes.
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   in_data   signed IN_W-bit operand
//   in_valid  operand valid
//   in_ready  idle and accepting an operand
//   out       packed float, [22:8] mantissa, [7:0] signed exponent
//   out_valid out holds a result
//   out_ready consumer accepts the result
module int_to_nr_float
  import nr_float_pkg::*;
#(
  parameter int IN_W = 24
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [MANTISSA_W+EXP_W-1:0]   out,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FIX_POINT_LOCATION);

  conv_state_e                   state_r, state_nxt_s;
  logic [IN_W-1:0]               mag_r, mag_nxt_s;
  logic [EXP_W-1:0]              exp_r, exp_nxt_s;
  logic                          sign_r, sign_nxt_s;
  logic [MANTISSA_W+EXP_W-1:0]   out_nxt_s;
  logic                          out_valid_nxt_s;
  logic                          in_ready_nxt_s;

  // Magnitude range tests that steer each normalisation step.
  logic mag_zero_s;
  logic mag_too_big_s;
  logic mag_too_small_s;

  // Range classification of the magnitude register.
  always_comb begin
    mag_zero_s      = (mag_r == '0);
    mag_too_big_s   = |mag_r[IN_W-1:FIX_POINT_LOCATION];
    // Only meaningful once the upper bits are known clear.
    mag_too_small_s = ~mag_r[FIX_POINT_LOCATION-1];
  end

  // Next-state and datapath update for the IDLE/NORM/DONE sequence.
  always_comb begin
    state_nxt_s     = state_r;
    mag_nxt_s       = mag_r;
    exp_nxt_s       = exp_r;
    sign_nxt_s      = sign_r;
    out_nxt_s       = out;
    out_valid_nxt_s = out_valid;
    in_ready_nxt_s  = in_ready;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sign_nxt_s     = in_data[IN_W-1];
          // The most negative input wraps onto itself, which read unsigned
          // is exactly its magnitude 2^(IN_W-1).
          if (in_data[IN_W-1]) begin
            mag_nxt_s = ~in_data + {{(IN_W-1){1'b0}}, 1'b1};
          end else begin
            mag_nxt_s = in_data;
          end
          exp_nxt_s      = EXP_INIT;
          in_ready_nxt_s = 1'b0;
          state_nxt_s    = ST_NORM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_zero_s) begin
          exp_nxt_s       = '0;
          out_nxt_s       = pack_float(1'b0, {FIX_POINT_LOCATION{1'b0}}, {EXP_W{1'b0}});
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_DONE;
        end else if (mag_too_big_s) begin
          // Dropped LSB truncates the magnitude: rounds toward zero.
          mag_nxt_s = mag_r >> 1;
          exp_nxt_s = exp_r + EXP_ONE;
        end else if (mag_too_small_s) begin
          mag_nxt_s = mag_r << 1;
          exp_nxt_s = exp_r - EXP_ONE;
        end else begin
          out_nxt_s       = pack_float(sign_r, mag_r[FIX_POINT_LOCATION-1:0], exp_r);
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) begin
          out_valid_nxt_s = 1'b0;
          in_ready_nxt_s  = 1'b1;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        out_valid_nxt_s = 1'b0;
        in_ready_nxt_s  = 1'b1;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      mag_r     <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      mag_r     <= mag_nxt_s;
      exp_r     <= exp_nxt_s;
      sign_r    <= sign_nxt_s;
      out       <= out_nxt_s;
      out_valid <= out_valid_nxt_s;
      in_ready  <= in_ready_nxt_s;
    end
  end

endmodule

// File: tb/tb_int_to_nr_float.sv
// Self-checking bench for int_to_nr_float: closed-form reference model of the
// conversion and its latency, directed cases, backpressure, reset abort and
// randomized traffic.
module tb_int_to_nr_float;

  localparam int IN_W = 24;

  logic            clk;
  logic            rstn;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [22:0]     out;
  logic            out_valid;
  logic            out_ready;

  int n_cmp;
  int n_bad;

  int_to_nr_float #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Closed-form conversion: exponent is bit-length of |v|, mantissa is |v|
  // scaled into [2^13, 2^14) with truncation, then negated for negative v.
  // Returns the number of shifts k.
  function automatic int model_conv(input logic signed [IN_W-1:0] v, output logic [22:0] res);
    longint a;
    longint m;
    int     p;
    int     e;
    logic [14:0] mant;
    logic [7:0]  ev;
    a = (v < 0) ? -longint'(v) : longint'(v);
    res = '0;
    if (a == 0) return 0;
    p = 0;
    for (int i = 0; i < 40; i++) if ((a >> i) != 0) p = i;
    e = p + 1;
    if (e >= 14) m = a >> (e - 14);
    else         m = a << (14 - e);
    if (v < 0) m = -m;
    mant = m[14:0];
    ev   = e[7:0];
    res  = {mant, ev};
    return (e >= 14) ? (e - 14) : (14 - e);
  endfunction

  // Transaction-level expectation of the outputs.
  int          m_cnt;
  logic        m_in_ready;
  logic        m_out_valid;
  logic [22:0] m_out;
  logic [22:0] m_pend;
  int          m_k;
  logic [22:0] m_res;

  always_comb m_k = model_conv(in_data, m_res);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_in_ready  <= 1'b1;
      m_out_valid <= 1'b0;
      m_out       <= '0;
      m_cnt       <= 0;
      m_pend      <= '0;
    end else if (m_in_ready) begin
      if (in_valid) begin
        m_in_ready <= 1'b0;
        m_cnt      <= m_k + 1;
        m_pend     <= m_res;
      end
    end else if (!m_out_valid) begin
      if (m_cnt == 1) begin
        m_out_valid <= 1'b1;
        m_out       <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_out_valid <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    if (rstn) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
      check("out", {9'd0, out}, {9'd0, m_out});
      check("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (in_ready) break;
      step();
    end
    if (!in_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic conv(input logic [IN_W-1:0] v, input logic [22:0] exp_out, input int exp_lat, input string name);
    int lat;
    wait_idle();
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = n - 1;
        break;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_out"}, {9'd0, out}, {9'd0, exp_out});
  endtask

  function automatic logic [IN_W-1:0] rand_val();
    logic [31:0]            r;
    logic signed [IN_W-1:0] t;
    int                     sel;
    sel = $urandom_range(0, 9);
    r   = $urandom;
    t   = r[IN_W-1:0];
    case (sel)
      0: return '0;
      1: return {1'b1, {(IN_W-1){1'b0}}};
      2: return r[0] ? {IN_W{1'b1}} : {{(IN_W-1){1'b0}}, 1'b1};
      default: return t >>> $urandom_range(0, IN_W - 1);
    endcase
  endfunction

  initial begin
    logic [22:0] res;
    logic [22:0] held;
    int          k;
    n_cmp     = 0;
    n_bad     = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Hand-computed values pin the reference model.
    k = model_conv(24'sd12288, res);
    check("model_12288", {9'd0, res}, {9'd0, 15'h3000, 8'd14});
    check("model_12288_k", k, 32'd0);
    k = model_conv(24'sd1, res);
    check("model_1", {9'd0, res}, {9'd0, 15'h2000, 8'd1});
    check("model_1_k", k, 32'd13);
    k = model_conv(-24'sd8388608, res);
    check("model_min", {9'd0, res}, {9'd0, 15'h6000, 8'd24});
    check("model_min_k", k, 32'd10);
    k = model_conv(24'sd16385, res);
    check("model_16385", {9'd0, res}, {9'd0, 15'h2000, 8'd15});
    k = model_conv(24'sd0, res);
    check("model_0", {9'd0, res}, 32'd0);

    // Reset state, then release with no operand.
    step();
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {9'd0, out}, 32'd0);
    rstn = 1'b1;
    step();
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_out", {9'd0, out}, 32'd0);

    // Directed conversions: latency counted in edges after the accept edge.
    conv(24'd12288, {15'h3000, 8'd14}, 1, "in_range");
    conv(24'd1, {15'h2000, 8'd1}, 14, "one");
    conv(24'h800000, {15'h6000, 8'd24}, 11, "most_neg");
    conv(24'd16385, {15'h2000, 8'd15}, 2, "trunc");
    conv(24'd0, 23'd0, 1, "zero");
    conv(24'hFFFFFF, {15'h6000, 8'd1}, 14, "minus_one");

    // Backpressure: result held, new operands ignored.
    wait_idle();
    step();
    out_ready = 1'b0;
    in_data   = 24'd12288;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) break;
      step();
    end
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held = out;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_data  = 24'd5;
      step();
      check("bp_hold_out", {9'd0, out}, {9'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of normalisation aborts with no result.
    wait_idle();
    in_data  = 24'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out", {9'd0, out}, 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rand_val();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
